// File: rtl/nco_sweep_pkg.sv
// rtl/nco_sweep_pkg.sv - shared widths and state encoding for the NCO chirp sequencer
package nco_sweep_pkg;

  localparam int APR     = 32;
  localparam int CW      = 16;
  localparam int NCO_LAT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    FLUSH = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/nco_sweep_dly.sv
// rtl/nco_sweep_dly.sv - clock-enable qualified 1-bit delay line with synchronous clear
module nco_sweep_dly #(
  parameter int DEPTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - linear chirp phase-increment sequencer with NCO-aligned output gate
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int apr = APR,
  parameter int cw  = CW,
  parameter int lat = NCO_LAT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic [apr-1:0] f_start,
  input  logic [apr-1:0] f_step,
  input  logic [cw-1:0]  n_steps,
  input  logic [cw-1:0]  dwell,
  output logic [apr-1:0] phi_inc_o,
  output logic           gate_o,
  output logic           busy,
  output logic           done,
  output logic           aborted
);

  localparam int FW = (lat > 1) ? $clog2(lat) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(lat - 1);

  sweep_state_e   state_q;
  logic [apr-1:0] phi_q, step_q, phi_sum_d;
  logic [cw-1:0]  dwell_last_q, steps_last_q, dwell_cnt_q, step_cnt_q;
  logic [FW-1:0]  flush_cnt_q;
  logic           done_q, aborted_q, kill_d;

  assign phi_sum_d = phi_q + step_q;
  assign kill_d    = abort && (state_q != IDLE);

  // Counters hold terminal values (n-1, dwell-1) so a zero field behaves as one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      phi_q        <= '0;
      step_q       <= '0;
      dwell_last_q <= '0;
      steps_last_q <= '0;
      dwell_cnt_q  <= '0;
      step_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (kill_d) begin
        state_q     <= IDLE;
        phi_q       <= '0;
        dwell_cnt_q <= '0;
        step_cnt_q  <= '0;
        flush_cnt_q <= '0;
        aborted_q   <= 1'b1;
      end else if (clken) begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q      <= RAMP;
              phi_q        <= f_start;
              step_q       <= f_step;
              dwell_last_q <= (dwell == '0) ? '0 : dwell - cw'(1);
              steps_last_q <= (n_steps == '0) ? '0 : n_steps - cw'(1);
              dwell_cnt_q  <= '0;
              step_cnt_q   <= '0;
            end
          end
          RAMP: begin
            if (dwell_cnt_q == dwell_last_q) begin
              dwell_cnt_q <= '0;
              if (step_cnt_q == steps_last_q) begin
                state_q     <= FLUSH;
                flush_cnt_q <= '0;
              end else begin
                phi_q      <= phi_sum_d;
                step_cnt_q <= step_cnt_q + cw'(1);
              end
            end else begin
              dwell_cnt_q <= dwell_cnt_q + cw'(1);
            end
          end
          FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
              state_q <= IDLE;
              phi_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              flush_cnt_q <= flush_cnt_q + FW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // RAMP delayed through the NCO latency marks which fsin samples belong to the chirp.
  nco_sweep_dly #(.DEPTH(lat)) u_gate_dly (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (clken),
    .clr_i (kill_d),
    .d_i   (state_q == RAMP),
    .q_o   (gate_o)
  );

  assign phi_inc_o = phi_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - scoreboard bench for the NCO chirp sequencer
module tb_nco_sweep_ctrl;
  import nco_sweep_pkg::*;

  localparam int LAT = NCO_LAT;

  typedef struct {
    logic [31:0] phi;
    logic        gate;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] f_start = '0;
  logic [31:0] f_step = '0;
  logic [15:0] n_steps = '0;
  logic [15:0] dwell = '0;
  logic [31:0] phi_inc_o;
  logic        gate_o, busy, done, aborted;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.apr(32), .cw(16), .lat(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_step    (f_step),
    .n_steps   (n_steps),
    .dwell     (dwell),
    .phi_inc_o (phi_inc_o),
    .gate_o    (gate_o),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t x, input logic ab);
    chk32({tag, ".phi"}, phi_inc_o, x.phi);
    chk1({tag, ".gate"}, gate_o, x.gate);
    chk1({tag, ".busy"}, busy, x.busy);
    chk1({tag, ".done"}, done, x.done);
    chk1({tag, ".aborted"}, aborted, ab);
  endtask

  // Expected trace is indexed by enabled edges since the start edge.
  task automatic run(input string name, input logic [31:0] fs, input logic [31:0] st,
                     input logic [15:0] n, input logic [15:0] d, input bit toggle,
                     input int abort_at);
    int   ne, de, nn, e, cyc;
    bit   en;
    exp_t cur, x;
    ne = (n == 0) ? 1 : int'(n);
    de = (d == 0) ? 1 : int'(d);
    nn = ne * de;
    for (int k = 0; k <= nn + LAT; k++) begin
      x.phi  = (k < nn) ? fs + 32'(k / de) * st :
               (k < nn + LAT) ? fs + 32'(ne - 1) * st : 32'h0;
      x.gate = (k >= LAT) && (k < nn + LAT);
      x.busy = (k < nn + LAT);
      x.done = (k == nn + LAT);
      sb.push_back(x);
    end
    f_start = fs; f_step = st; n_steps = n; dwell = d;
    start = 1'b1; clken = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    f_start = $urandom; f_step = $urandom;
    n_steps = 16'($urandom); dwell = 16'($urandom);
    cur = sb.pop_front();
    check_all({name, ".first"}, cur, 1'b0);
    e = 0; en = 1'b1; cyc = 0;
    while (sb.size() > 0) begin
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL %s.timeout observed=%0d pending expected=0", name, sb.size());
        sb.delete();
        break;
      end
      en = toggle ? !en : 1'b1;
      if (abort_at >= 0 && e == abort_at) begin
        abort = 1'b1; clken = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        x.phi = 32'h0; x.gate = 1'b0; x.busy = 1'b0; x.done = 1'b0;
        check_all({name, ".abort"}, x, 1'b1);
        sb.delete();
        clken = 1'b1;
        @(posedge clk); #1;
        check_all({name, ".post_abort"}, x, 1'b0);
        return;
      end
      start = (e == 2);
      clken = en;
      @(posedge clk); #1;
      start = 1'b0;
      if (en) begin
        e++;
        cur = sb.pop_front();
        check_all({name, ".step"}, cur, 1'b0);
      end else begin
        x = cur;
        x.done = 1'b0;
        check_all({name, ".hold"}, x, 1'b0);
      end
    end
    clken = 1'b1;
  endtask

  initial begin
    exp_t z;
    z.phi = 32'h0; z.gate = 1'b0; z.busy = 1'b0; z.done = 1'b0;

    #12;
    check_all("reset", z, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clken = 1'b1;

    run("basic", 32'h0100_0000, 32'h0001_0000, 16'd4, 16'd3, 1'b0, -1);
    run("negwrap", 32'h0000_0010, 32'hFFFF_FFF0, 16'd3, 16'd1, 1'b0, -1);
    run("toggle", 32'h0100_0000, 32'h0001_0000, 16'd4, 16'd3, 1'b1, -1);
    run("abort", 32'h2000_0000, 32'h0010_0000, 16'd8, 16'd8, 1'b0, 18);
    run("after_abort", 32'h2000_0000, 32'h0010_0000, 16'd2, 16'd3, 1'b0, -1);

    start = 1'b1; abort = 1'b1; clken = 1'b1; f_start = 32'h1234_5678;
    n_steps = 16'd2; dwell = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_all("start_abort_idle", z, 1'b0);
    @(posedge clk); #1;
    check_all("start_abort_idle2", z, 1'b0);

    run("zero", 32'h0555_0000, 32'h0000_0001, 16'd0, 16'd0, 1'b0, -1);

    f_start = 32'hABCD_0000; f_step = 32'h0000_0100; n_steps = 16'd4; dwell = 16'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("midreset.busy_before", busy, 1'b1);
    chk32("midreset.phi_before", phi_inc_o, 32'hABCD_0000);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_all("midreset", z, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run("post_reset", 32'h0000_0100, 32'h0000_0001, 16'd2, 16'd2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
